// File: rtl/bgr_startup_ctrl_if.sv
// Signal bundle between the bandgap start-up sequencer and its environment.
// Trim signals are present only when BGR_TRIM_EN is defined.
interface bgr_startup_ctrl_if #(
    parameter int unsigned RW = 2
`ifdef BGR_TRIM_EN
    ,
    parameter int unsigned TRIM_W = 4
`endif
);
    logic          enable;
    logic          vbg_ok;
    logic          porst;
    logic          bgr_ready;
    logic          bgr_fault;
    logic [RW-1:0] retry_cnt;
`ifdef BGR_TRIM_EN
    logic [TRIM_W-1:0] trim_in;
    logic              trim_load;
    logic [TRIM_W-1:0] trim_code;
`endif

    modport master (
        output enable,
        output vbg_ok,
        input  porst,
        input  bgr_ready,
        input  bgr_fault,
        input  retry_cnt
`ifdef BGR_TRIM_EN
        ,
        output trim_in,
        output trim_load,
        input  trim_code
`endif
    );

    modport slave (
        input  enable,
        input  vbg_ok,
        output porst,
        output bgr_ready,
        output bgr_fault,
        output retry_cnt
`ifdef BGR_TRIM_EN
        ,
        input  trim_in,
        input  trim_load,
        output trim_code
`endif
    );
endinterface

// File: rtl/bgr_startup_ctrl.sv
// Bandgap start-up sequencer: kick, settle, debounce vbg_ok, retry, sticky fault.
// Define BGR_TRIM_EN to add the loadable trim register and its re-settle behaviour.
module bgr_startup_ctrl #(
`ifdef BGR_TRIM_EN
    parameter int unsigned TRIM_W        = 4,
    parameter int unsigned TRIM_DEFAULT  = 8,
`endif
    parameter int unsigned KICK_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter int unsigned DEBOUNCE      = 4,
    parameter int unsigned CHECK_TIMEOUT = 256,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input logic               clk,
    input logic               rst,
    bgr_startup_ctrl_if.slave bus
);
    localparam int unsigned CntMax0 = (KICK_CYCLES > SETTLE_CYCLES) ? KICK_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CntMax  = (CntMax0 > CHECK_TIMEOUT) ? CntMax0 : CHECK_TIMEOUT;
    localparam int unsigned CW      = $clog2(CntMax + 1);
    localparam int unsigned DW      = $clog2(DEBOUNCE + 1);
    localparam int unsigned RetryW  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CW-1:0] KickLoad   = CW'(KICK_CYCLES - 1);
    localparam logic [CW-1:0] SettleLoad = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] CheckLoad  = CW'(CHECK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StKick,
        StSettle,
        StCheck,
        StReady,
        StFault
    } state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [DW-1:0]     run_q;
    logic [RetryW-1:0] retry_q;
    logic              porst_q;
    logic              ready_q;
    logic              fault_q;
    logic [1:0]        sync_q;

    logic ok_s;
    logic run_done;
    logic retry_left;
    logic timeout;
    logic lost;
    logic restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], bus.vbg_ok};
        end
    end

    assign ok_s       = sync_q[1];
    // run_q counts consecutive good samples in CHECK and consecutive bad samples in READY
    assign run_done   = (run_q == DW'(DEBOUNCE - 1));
    assign retry_left = (retry_q < RetryW'(MAX_RETRIES));
    // Qualification on the timeout cycle takes precedence over the timeout
    assign timeout    = (state_q == StCheck) && (cnt_q == '0) && !(ok_s && run_done);
    assign lost       = (state_q == StReady) && !ok_s && run_done;

`ifdef BGR_TRIM_EN
    logic [TRIM_W-1:0] trim_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            trim_q <= TRIM_W'(TRIM_DEFAULT);
        end else if (bus.trim_load) begin
            trim_q <= bus.trim_in;
        end
    end

    assign bus.trim_code = trim_q;
    assign restart = bus.trim_load && ((state_q == StCheck) || (state_q == StReady));
`else
    assign restart = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            run_q   <= '0;
            retry_q <= '0;
            porst_q <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (!bus.enable) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            run_q   <= '0;
            retry_q <= '0;
            porst_q <= 1'b0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (restart) begin
            state_q <= StSettle;
            cnt_q   <= SettleLoad;
            run_q   <= '0;
            ready_q <= 1'b0;
        end else if (timeout || lost) begin
            run_q   <= '0;
            ready_q <= 1'b0;
            if (retry_left) begin
                state_q <= StKick;
                cnt_q   <= KickLoad;
                retry_q <= retry_q + 1'b1;
                porst_q <= 1'b1;
            end else begin
                state_q <= StFault;
                fault_q <= 1'b1;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StKick;
                    cnt_q   <= KickLoad;
                    porst_q <= 1'b1;
                end
                StKick: begin
                    if (cnt_q == '0) begin
                        state_q <= StSettle;
                        cnt_q   <= SettleLoad;
                        porst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StSettle: begin
                    if (cnt_q == '0) begin
                        state_q <= StCheck;
                        cnt_q   <= CheckLoad;
                        run_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StCheck: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                    if (!ok_s) begin
                        run_q <= '0;
                    end else if (run_done) begin
                        state_q <= StReady;
                        run_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        run_q <= run_q + 1'b1;
                    end
                end
                StReady: begin
                    if (ok_s) begin
                        run_q <= '0;
                    end else begin
                        run_q <= run_q + 1'b1;
                    end
                end
                StFault: begin
                    porst_q <= 1'b0;
                    ready_q <= 1'b0;
                    fault_q <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.porst     = porst_q;
    assign bus.bgr_ready = ready_q;
    assign bus.bgr_fault = fault_q;
    assign bus.retry_cnt = retry_q;
endmodule

// File: tb/tb_bgr_startup_ctrl.sv
// Directed bench for bgr_startup_ctrl: nominal, slow start, dead core, glitch, abort, reset,
// and the BGR_TRIM_EN reload when that macro is defined.
module tb_bgr_startup_ctrl;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   n;
    int   porst_hi;
    int   porst_rise;
    logic porst_prev;
    logic overlap;

`ifdef BGR_TRIM_EN
    bgr_startup_ctrl_if #(.RW(2), .TRIM_W(4)) bus ();
`else
    bgr_startup_ctrl_if #(.RW(2)) bus ();
`endif

    bgr_startup_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.porst && bus.bgr_ready) overlap = 1'b1;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance k edges; n counts edges since the last reset of the counter.
    task automatic adv(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.porst) porst_hi++;
            if (bus.porst && !porst_prev) porst_rise++;
            porst_prev = bus.porst;
        end
    endtask

    task automatic restart_count();
        n          = 0;
        porst_hi   = 0;
        porst_rise = 0;
        porst_prev = bus.porst;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        overlap   = 1'b0;
        rst       = 1'b1;
        bus.enable = 1'b0;
        bus.vbg_ok = 1'b1;
`ifdef BGR_TRIM_EN
        bus.trim_in   = 4'd0;
        bus.trim_load = 1'b0;
`endif
        restart_count();
        adv(2);
        check_eq("rst_porst", int'(bus.porst), 0);
        check_eq("rst_ready", int'(bus.bgr_ready), 0);
        check_eq("rst_fault", int'(bus.bgr_fault), 0);
        check_eq("rst_retry", int'(bus.retry_cnt), 0);
        rst = 1'b0;

        // Nominal start
        bus.enable = 1'b1;
        restart_count();
        adv(1);
        check_eq("nom_porst_c1", int'(bus.porst), 1);
        adv(15);
        check_eq("nom_porst_c16", int'(bus.porst), 1);
        adv(1);
        check_eq("nom_porst_c17", int'(bus.porst), 0);
        adv(67);
        check_eq("nom_ready_c84", int'(bus.bgr_ready), 0);
        adv(1);
        check_eq("nom_ready_c85", int'(bus.bgr_ready), 1);
        check_eq("nom_retry", int'(bus.retry_cnt), 0);
        check_eq("nom_porst_width", porst_hi, 16);

        // Glitch of 3 synchronized lows is tolerated
        bus.vbg_ok = 1'b0;
        adv(3);
        bus.vbg_ok = 1'b1;
        adv(5);
        check_eq("glitch3_ready", int'(bus.bgr_ready), 1);

        // 4 lows drop ready and kick again
        bus.vbg_ok = 1'b0;
        adv(5);
        check_eq("glitch4_ready_hold", int'(bus.bgr_ready), 1);
        adv(1);
        bus.vbg_ok = 1'b1;
        check_eq("glitch4_ready", int'(bus.bgr_ready), 0);
        check_eq("glitch4_porst", int'(bus.porst), 1);
        check_eq("glitch4_retry", int'(bus.retry_cnt), 1);
        adv(83);
        check_eq("glitch4_reready_early", int'(bus.bgr_ready), 0);
        adv(1);
        check_eq("glitch4_reready", int'(bus.bgr_ready), 1);

        // Reset while READY
        rst = 1'b1;
        adv(1);
        check_eq("rstrdy_ready", int'(bus.bgr_ready), 0);
        check_eq("rstrdy_porst", int'(bus.porst), 0);
        check_eq("rstrdy_fault", int'(bus.bgr_fault), 0);
        check_eq("rstrdy_retry", int'(bus.retry_cnt), 0);
        rst = 1'b0;
        bus.enable = 1'b0;
        adv(2);

        // Abort mid-kick
        bus.enable = 1'b1;
        restart_count();
        adv(5);
        check_eq("abort_porst_c5", int'(bus.porst), 1);
        bus.enable = 1'b0;
        adv(1);
        check_eq("abort_porst", int'(bus.porst), 0);
        adv(3);
        check_eq("abort_idle_porst", int'(bus.porst), 0);

        // Slow start: one timeout then ready
        bus.vbg_ok = 1'b0;
        bus.enable = 1'b1;
        restart_count();
        adv(336);
        check_eq("slow_porst_c336", int'(bus.porst), 0);
        check_eq("slow_retry_c336", int'(bus.retry_cnt), 0);
        adv(1);
        check_eq("slow_porst_c337", int'(bus.porst), 1);
        check_eq("slow_retry_c337", int'(bus.retry_cnt), 1);
        adv(15);
        check_eq("slow_porst_c352", int'(bus.porst), 1);
        adv(1);
        check_eq("slow_porst_c353", int'(bus.porst), 0);
        adv(7);
        bus.vbg_ok = 1'b1;
        adv(60);
        check_eq("slow_ready_c420", int'(bus.bgr_ready), 0);
        adv(1);
        check_eq("slow_ready_c421", int'(bus.bgr_ready), 1);
        check_eq("slow_retry", int'(bus.retry_cnt), 1);
        check_eq("slow_pulses", porst_rise, 2);
        check_eq("slow_porst_width", porst_hi, 32);

        // Dead core: retries exhausted
        bus.enable = 1'b0;
        adv(1);
        bus.vbg_ok = 1'b0;
        bus.enable = 1'b1;
        restart_count();
        adv(1344);
        check_eq("dead_fault_c1344", int'(bus.bgr_fault), 0);
        adv(1);
        check_eq("dead_fault_c1345", int'(bus.bgr_fault), 1);
        check_eq("dead_retry", int'(bus.retry_cnt), 3);
        adv(20);
        check_eq("dead_fault_hold", int'(bus.bgr_fault), 1);
        check_eq("dead_porst", int'(bus.porst), 0);
        check_eq("dead_ready", int'(bus.bgr_ready), 0);
        check_eq("dead_pulses", porst_rise, 4);
        check_eq("dead_porst_width", porst_hi, 64);
        bus.enable = 1'b0;
        adv(1);
        check_eq("dead_clear_fault", int'(bus.bgr_fault), 0);
        check_eq("dead_clear_retry", int'(bus.retry_cnt), 0);

`ifdef BGR_TRIM_EN
        // Trim reload in READY forces a re-settle
        bus.vbg_ok = 1'b1;
        bus.enable = 1'b1;
        restart_count();
        adv(85);
        check_eq("trim_pre_ready", int'(bus.bgr_ready), 1);
        check_eq("trim_default", int'(bus.trim_code), 8);
        bus.trim_in   = 4'd11;
        bus.trim_load = 1'b1;
        restart_count();
        adv(1);
        bus.trim_load = 1'b0;
        check_eq("trim_code", int'(bus.trim_code), 11);
        check_eq("trim_ready_drop", int'(bus.bgr_ready), 0);
        adv(67);
        check_eq("trim_ready_c68", int'(bus.bgr_ready), 0);
        adv(1);
        check_eq("trim_ready_c69", int'(bus.bgr_ready), 1);
        check_eq("trim_retry", int'(bus.retry_cnt), 0);
        check_eq("trim_no_kick", porst_hi, 0);
`endif

        check_eq("porst_ready_overlap", int'(overlap), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
